mem_interface_unit: RTL and testbench

- Memory-side stage that consumes the 32-bit datapath bus (`bus_mux_out`) and produces the MDR word that the bus multiplexer places on the bus in slot 21.
- Holds the memory address register (MAR) and memory data register (MDR).
- Runs a single-outstanding read/write handshake against the RAM, so the control unit issues one pulse per transaction and then waits on `mem_done`.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mem_interface_unit_mdr_reg.sv | 41 ++++
 rtl/mem_interface_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_interface_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the memory interface stage: FSM state encoding,
// address/timeout defaults and the bus multiplexer slot that carries the MDR.
package cpu_mem_pkg;

  localparam int unsigned CPU_MEM_ADDR_W   = 9;
  localparam int unsigned CPU_MEM_TIMEOUT  = 16;
  localparam int unsigned CPU_MEM_MDR_SLOT = 21;

  typedef enum logic [2:0] {
    MS_IDLE = 3'd0,
    MS_RD   = 3'd1,
    MS_WR   = 3'd2,
    MS_DONE = 3'd3,
    MS_ERR  = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_interface_unit_mdr_reg.sv
// Memory data register: 32-bit word loaded either from the datapath bus or from
// RAM read data, with load enable and synchronous clear.
module mdr_reg (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic        sel_mem_i,
  input  logic [31:0] bus_i,
  input  logic [31:0] mem_i,
  output logic [31:0] q_o
);

  logic [31:0] mdr_q;
  logic [31:0] mdr_d;

  // Select the source and hold when not loading.
  always_comb begin
    mdr_d = mdr_q;
    if (load_i) begin
      if (sel_mem_i) begin
        mdr_d = mem_i;
      end else begin
        mdr_d = bus_i;
      end
    end else begin
      mdr_d = mdr_q;
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mdr_q <= 32'h0000_0000;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  assign q_o = mdr_q;

endmodule

// File: rtl/mem_interface_unit.sv
// Memory-side stage: MAR/MDR plus a single-outstanding RAM read/write handshake.
// Define MEM_TIMEOUT_EN to compile in the ready timeout counter and ERR state.
module mem_interface_unit
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = CPU_MEM_ADDR_W,
  parameter int unsigned TIMEOUT = CPU_MEM_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       bus_mux_out,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_out,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       bus_mux_in_mdr,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);

  localparam logic [2:0] ST_IDLE = 3'(MS_IDLE);
  localparam logic [2:0] ST_RD   = 3'(MS_RD);
  localparam logic [2:0] ST_WR   = 3'(MS_WR);
  localparam logic [2:0] ST_DONE = 3'(MS_DONE);
  localparam logic [2:0] ST_ERR  = 3'(MS_ERR);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] mar_d;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              mem_busy_q;
  logic              mem_done_q;
  logic              in_xfer_s;
  logic              reg_load_ok_s;
  logic              timeout_s;
  logic              mdr_load_s;
  logic              mdr_sel_mem_s;
  logic [31:0]       mdr_s;

  assign in_xfer_s     = (state_q == ST_RD) || (state_q == ST_WR);
  assign reg_load_ok_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mem_err_q;

  // Counter is zero outside RD/WR, so entering a transfer always starts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (in_xfer_s) begin
      if (!mem_ready) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = in_xfer_s && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Error pulse register, decoded from the next state.
  always_ff @(posedge clock) begin
    if (clear) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= (state_d == ST_ERR);
    end
  end

  assign mem_err = mem_err_q;
`else
  assign timeout_s = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Next-state logic; mem_ready wins over a timeout on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (read) begin
          state_d = ST_RD;
        end else if (write) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
      ST_ERR:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // MAR only accepts the bus when no transfer is in flight.
  always_comb begin
    mar_d = mar_q;
    if (mar_in && reg_load_ok_s) begin
      mar_d = bus_mux_out[ADDR_W-1:0];
    end else begin
      mar_d = mar_q;
    end
  end

  // State, MAR and strobe registers; strobes are registered copies of the next state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      mar_q      <= {ADDR_W{1'b0}};
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_busy_q <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mem_rd_q   <= (state_d == ST_RD);
      mem_wr_q   <= (state_d == ST_WR);
      mem_busy_q <= (state_d == ST_RD) || (state_d == ST_WR);
      mem_done_q <= (state_d == ST_DONE);
    end
  end

  assign mdr_sel_mem_s = (state_q == ST_RD);
  assign mdr_load_s    = (mdr_sel_mem_s && mem_ready) || (mdr_in && reg_load_ok_s);

  mdr_reg u_mdr (
    .clk_i     (clock),
    .clr_i     (clear),
    .load_i    (mdr_load_s),
    .sel_mem_i (mdr_sel_mem_s),
    .bus_i     (bus_mux_out),
    .mem_i     (mem_data_in),
    .q_o       (mdr_s)
  );

  assign mem_addr       = mar_q;
  assign mem_data_out   = mdr_s;
  assign bus_mux_in_mdr = mdr_s;
  assign mem_rd         = mem_rd_q;
  assign mem_wr         = mem_wr_q;
  assign mem_busy       = mem_busy_q;
  assign mem_done       = mem_done_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Scoreboard bench for mem_interface_unit: stimulus pushes expected completions,
// a negedge monitor pops and compares on every mem_done/mem_err pulse.
module tb_mem_interface_unit;

  logic        clock;
  logic        clear;
  logic [31:0] bus_mux_out;
  logic        mar_in;
  logic        mdr_in;
  logic        read;
  logic        write;
  logic [31:0] mem_data_in;
  logic        mem_ready;
  logic [8:0]  mem_addr;
  logic [31:0] mem_data_out;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] bus_mux_in_mdr;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_err;

  typedef struct {
    logic        is_err;
    logic [31:0] mdr;
    logic [8:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_interface_unit #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .clock          (clock),
    .clear          (clear),
    .bus_mux_out    (bus_mux_out),
    .mar_in         (mar_in),
    .mdr_in         (mdr_in),
    .read           (read),
    .write          (write),
    .mem_data_in    (mem_data_in),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .bus_mux_in_mdr (bus_mux_in_mdr),
    .mem_busy       (mem_busy),
    .mem_done       (mem_done),
    .mem_err        (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic is_err, input logic [31:0] mdr, input logic [8:0] addr);
    exp_t e;
    e.is_err = is_err;
    e.mdr    = mdr;
    e.addr   = addr;
    exp_q.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (mem_done || mem_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", {mem_done, mem_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_kind", {mem_done, mem_err}, e.is_err ? 32'd1 : 32'd2);
        check("sb_mdr", bus_mux_in_mdr, e.mdr);
        check("sb_addr", {23'd0, mem_addr}, {23'd0, e.addr});
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"}, {23'd0, mem_addr}, 32'd0);
    check({tag, "_dout"}, mem_data_out, 32'd0);
    check({tag, "_mdr"}, bus_mux_in_mdr, 32'd0);
    check({tag, "_strobes"}, {mem_rd, mem_wr, mem_busy, mem_done, mem_err}, 32'd0);
  endtask

  task automatic load_reg(input logic do_mar, input logic [31:0] val);
    bus_mux_out = val;
    mar_in = do_mar;
    mdr_in = ~do_mar;
    tick();
    mar_in = 1'b0;
    mdr_in = 1'b0;
  endtask

  // One transaction: issue request, then observe ncyc cycles counting strobes.
  task automatic txn(input logic rd, input logic wr, input int ready_at, input int ncyc,
                     input logic poke, input logic [31:0] rdata,
                     output int rd_cnt, output int wr_cnt, output int done_cnt,
                     output int err_cnt, output logic stable);
    logic [31:0] ref_dout;
    logic [8:0]  ref_addr;
    ref_dout = mem_data_out;
    ref_addr = mem_addr;
    read  = rd;
    write = wr;
    tick();
    read  = 1'b0;
    write = 1'b0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; stable = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      rd_cnt   = rd_cnt + int'(mem_rd);
      wr_cnt   = wr_cnt + int'(mem_wr);
      done_cnt = done_cnt + int'(mem_done);
      err_cnt  = err_cnt + int'(mem_err);
      if (mem_data_out !== ref_dout || mem_addr !== ref_addr) stable = 1'b0;
      if (i == 0 && poke) begin
        read = 1'b1; mdr_in = 1'b1; mar_in = 1'b1; bus_mux_out = 32'hFFFF_FFFF;
      end
      if (i == ready_at) begin
        mem_ready = 1'b1; mem_data_in = rdata;
      end
      tick();
      read = 1'b0; mdr_in = 1'b0; mar_in = 1'b0; mem_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, wc, dc, ec;
    logic st;

    // Reset with junk on every input.
    clear = 1'b1; bus_mux_out = 32'hA5A5_A5A5; mar_in = 1'b1; mdr_in = 1'b1;
    read = 1'b1; write = 1'b1; mem_data_in = 32'h5A5A_5A5A; mem_ready = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset");
    clear = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; read = 1'b0; write = 1'b0;
    mem_ready = 1'b0; bus_mux_out = 32'h0;
    tick();
    check_idle_zero("post_reset");

    // Read: ready on third RD cycle.
    load_reg(1'b1, 32'h0000_0042);
    check("mar_load", {23'd0, mem_addr}, 32'h0000_0042);
    push(1'b0, 32'hDEAD_BEEF, 9'h042);
    txn(1'b1, 1'b0, 2, 6, 1'b0, 32'hDEAD_BEEF, rc, wc, dc, ec, st);
    check("read_rd_cycles", rc, 32'd3);
    check("read_done_pulses", dc, 32'd1);
    check("read_no_wr", wc, 32'd0);
    check("read_data", bus_mux_in_mdr, 32'hDEAD_BEEF);

    // Write with MDR/MAR pokes while busy.
    load_reg(1'b0, 32'h1234_5678);
    check("mdr_load", mem_data_out, 32'h1234_5678);
    push(1'b0, 32'h1234_5678, 9'h042);
    txn(1'b0, 1'b1, 1, 6, 1'b1, 32'h0, rc, wc, dc, ec, st);
    check("write_wr_cycles", wc, 32'd2);
    check("write_done_pulses", dc, 32'd1);
    check("write_stable", {31'd0, st}, 32'd1);
    check("write_dout", mem_data_out, 32'h1234_5678);

    // Simultaneous read+write: read wins, a second read during RD is ignored.
    push(1'b0, 32'hA5A5_0F0F, 9'h042);
    txn(1'b1, 1'b1, 1, 6, 1'b1, 32'hA5A5_0F0F, rc, wc, dc, ec, st);
    check("rw_rd_cycles", rc, 32'd2);
    check("rw_no_wr", wc, 32'd0);
    check("rw_done_pulses", dc, 32'd1);

    // Minimum-latency read at the top address.
    load_reg(1'b1, 32'hFFFF_FFFF);
    check("mar_max", {23'd0, mem_addr}, 32'h0000_01FF);
    push(1'b0, 32'h0BAD_F00D, 9'h1FF);
    txn(1'b1, 1'b0, 0, 4, 1'b0, 32'h0BAD_F00D, rc, wc, dc, ec, st);
    check("minlat_rd_cycles", rc, 32'd1);
    check("minlat_data", bus_mux_in_mdr, 32'h0BAD_F00D);

    // mem_ready in IDLE is ignored.
    mem_ready = 1'b1; mem_data_in = 32'h1111_1111;
    tick();
    mem_ready = 1'b0;
    tick();
    check("idle_ready_mdr", bus_mux_in_mdr, 32'h0BAD_F00D);
    check("idle_ready_busy", {mem_busy, mem_rd}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    push(1'b1, 32'h0BAD_F00D, 9'h1FF);
    txn(1'b1, 1'b0, -1, 20, 1'b0, 32'h0, rc, wc, dc, ec, st);
    check("timeout_rd_cycles", rc, 32'd16);
    check("timeout_err_pulses", ec, 32'd1);
    check("timeout_no_done", dc, 32'd0);
    check("timeout_mdr", bus_mux_in_mdr, 32'h0BAD_F00D);
    check("timeout_idle", {mem_busy, mem_rd}, 32'd0);
`else
    txn(1'b1, 1'b0, -1, 110, 1'b0, 32'h0, rc, wc, dc, ec, st);
    check("notimeout_rd_cycles", rc, 32'd110);
    check("notimeout_err", ec, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_zero("notimeout_abort");
`endif

    // Clear during second WR cycle aborts without a completion.
    load_reg(1'b1, 32'h0000_0077);
    load_reg(1'b0, 32'hCAFE_0001);
    write = 1'b1;
    tick();
    write = 1'b0;
    check("abort_wr_c1", {31'd0, mem_wr}, 32'd1);
    tick();
    check("abort_wr_c2", {31'd0, mem_wr}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_zero("abort");
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      dc = dc + int'(mem_done);
      tick();
    end
    check("abort_no_done", dc, 32'd0);

    tick();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
